// File: rtl/latch_debouncer_pkg.sv
// Shared types and constants for the latch-output debouncer.
`timescale 1ns/1ps
package latch_debouncer_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } dbnc_state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int DEBOUNCE_MIN    = 2;
    localparam int DEBOUNCE_MAX    = 255;
    localparam int DEBOUNCE_DFLT   = 4;

    function automatic int tmr_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int TMR_W = tmr_width(DEBOUNCE_DFLT);

endpackage

// File: rtl/latch_debouncer_sync.sv
// Multi-flop synchroniser bringing the asynchronous latch level into clk.
`timescale 1ns/1ps
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/latch_debouncer.sv
// Debounces a glitchy latch output: synchronise, qualify level changes, emit
// clean level, edge/glitch pulses and a wrapping count of accepted rises.
//
//   state      | meaning
//   S_LOW      | level accepted as 0, waiting for a candidate 1
//   S_RISE_CHK | candidate 1 being timed
//   S_HIGH     | level accepted as 1, waiting for a candidate 0
//   S_FALL_CHK | candidate 0 being timed
`timescale 1ns/1ps
module latch_debouncer
    import latch_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DFLT,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_in,
    input  logic             en,
    input  logic             clr_cnt,
    output logic             q_stable,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             glitch_pulse,
    output logic [CNT_W-1:0] event_cnt,
    output logic             cnt_overflow
);

    localparam int TIMER_W = tmr_width(DEBOUNCE_CYCLES);
    localparam logic [TIMER_W-1:0] TMR_LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("latch_debouncer: SYNC_STAGES out of range");
    end
    if (DEBOUNCE_CYCLES < DEBOUNCE_MIN || DEBOUNCE_CYCLES > DEBOUNCE_MAX) begin : g_bad_dbnc
        $error("latch_debouncer: DEBOUNCE_CYCLES out of range");
    end

    logic               s;
    dbnc_state_t        state, state_nxt;
    logic [TIMER_W-1:0] tmr, tmr_nxt;
    logic               q_nxt, rise_nxt, fall_nxt, glitch_nxt;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (d_in),
        .q     (s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_LOW;
            tmr          <= '0;
            q_stable     <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            glitch_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            tmr          <= tmr_nxt;
            q_stable     <= q_nxt;
            rise_pulse   <= rise_nxt;
            fall_pulse   <= fall_nxt;
            glitch_pulse <= glitch_nxt;
        end
    end

    // Dropping en abandons a pending check silently rather than flagging a glitch.
    always_comb begin
        state_nxt  = state;
        tmr_nxt    = tmr;
        q_nxt      = q_stable;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        glitch_nxt = 1'b0;
        case (state)
            S_LOW: begin
                if (en && s) begin
                    state_nxt = S_RISE_CHK;
                    tmr_nxt   = TIMER_W'(1);
                end
            end
            S_RISE_CHK: begin
                if (!en) begin
                    state_nxt = S_LOW;
                end else if (!s) begin
                    state_nxt  = S_LOW;
                    glitch_nxt = 1'b1;
                end else if (tmr == TMR_LAST) begin
                    state_nxt = S_HIGH;
                    q_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    tmr_nxt = tmr + TIMER_W'(1);
                end
            end
            S_HIGH: begin
                if (en && !s) begin
                    state_nxt = S_FALL_CHK;
                    tmr_nxt   = TIMER_W'(1);
                end
            end
            S_FALL_CHK: begin
                if (!en) begin
                    state_nxt = S_HIGH;
                end else if (s) begin
                    state_nxt  = S_HIGH;
                    glitch_nxt = 1'b1;
                end else if (tmr == TMR_LAST) begin
                    state_nxt = S_LOW;
                    q_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    tmr_nxt = tmr + TIMER_W'(1);
                end
            end
            default: state_nxt = S_LOW;
        endcase
    end

    // A clear coinciding with an acceptance drops that event from the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            event_cnt    <= '0;
            cnt_overflow <= 1'b0;
        end else if (clr_cnt) begin
            event_cnt    <= '0;
            cnt_overflow <= 1'b0;
        end else if (rise_nxt) begin
            event_cnt <= event_cnt + CNT_W'(1);
            if (&event_cnt) begin
                cnt_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_latch_debouncer.sv
// Directed, table-driven bench for latch_debouncer (CNT_W=2 to reach the wrap quickly).
`timescale 1ns/1ps
module tb_latch_debouncer;

    typedef struct {
        logic       d;
        logic       en;
        logic       clr;
        logic       q;
        logic       r;
        logic       f;
        logic       g;
        logic [1:0] cnt;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_in;
    logic       en;
    logic       clr_cnt;
    logic       q_stable;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       glitch_pulse;
    logic [1:0] event_cnt;
    logic       cnt_overflow;

    int checks   = 0;
    int failures = 0;

    vec_t       vecs[$];
    logic       m_q   = 1'b0;
    logic [1:0] m_cnt = 2'd0;
    logic       m_ovf = 1'b0;

    latch_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .d_in         (d_in),
        .en           (en),
        .clr_cnt      (clr_cnt),
        .q_stable     (q_stable),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .glitch_pulse (glitch_pulse),
        .event_cnt    (event_cnt),
        .cnt_overflow (cnt_overflow)
    );

    always #20 clk = ~clk;

    function automatic vec_t mk(logic d, logic e, logic c, logic q, logic r,
                                logic f, logic g, logic [1:0] cnt, logic ovf);
        vec_t v;
        v.d = d; v.en = e; v.clr = c; v.q = q; v.r = r; v.f = f; v.g = g;
        v.cnt = cnt; v.ovf = ovf;
        return v;
    endfunction

    function automatic void add(logic d, logic e, logic g);
        vecs.push_back(mk(d, e, 1'b0, m_q, 1'b0, 1'b0, g, m_cnt, m_ovf));
    endfunction

    // pre rows of a held level, then the acceptance row, then hold rows
    function automatic void add_accept(logic lvl, logic clr_acc, int pre, int hold);
        for (int i = 0; i < pre; i++) add(lvl, 1'b1, 1'b0);
        m_q = lvl;
        if (lvl) begin
            if (clr_acc) begin
                m_cnt = 2'd0;
                m_ovf = 1'b0;
            end else begin
                if (m_cnt == 2'd3) m_ovf = 1'b1;
                m_cnt = m_cnt + 2'd1;
            end
        end
        vecs.push_back(mk(lvl, 1'b1, clr_acc, m_q, lvl, ~lvl, 1'b0, m_cnt, m_ovf));
        for (int i = 0; i < hold; i++) add(lvl, 1'b1, 1'b0);
    endfunction

    task automatic chk(string nm, int idx, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_outs(string tag, int idx, vec_t v);
        chk({tag, ".q_stable"},     idx, 8'(q_stable),     8'(v.q));
        chk({tag, ".rise_pulse"},   idx, 8'(rise_pulse),   8'(v.r));
        chk({tag, ".fall_pulse"},   idx, 8'(fall_pulse),   8'(v.f));
        chk({tag, ".glitch_pulse"}, idx, 8'(glitch_pulse), 8'(v.g));
        chk({tag, ".event_cnt"},    idx, 8'(event_cnt),    8'(v.cnt));
        chk({tag, ".cnt_overflow"}, idx, 8'(cnt_overflow), 8'(v.ovf));
    endtask

    task automatic step(string tag, int idx, vec_t v);
        d_in    = v.d;
        en      = v.en;
        clr_cnt = v.clr;
        @(posedge clk);
        #1;
        chk_outs(tag, idx, v);
    endtask

    initial begin
        vec_t zero;
        zero = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        // clean rise, clean fall held for 20 cycles
        add_accept(1'b1, 1'b0, 5, 2);
        add_accept(1'b0, 1'b0, 5, 14);
        // two-cycle blip -> one glitch
        add(1'b1, 1'b1, 1'b0); add(1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0); add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1); add(1'b0, 1'b1, 1'b0);
        // toggling every cycle: a glitch per candidate, never an acceptance
        for (int i = 1; i <= 34; i++)
            add((i <= 30) ? logic'(i % 2) : 1'b0, 1'b1,
                (i >= 4 && i % 2 == 0 && i <= 32) ? 1'b1 : 1'b0);
        // en dropped two cycles into the rise check, then restored
        for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0);
        add_accept(1'b1, 1'b0, 3, 1);
        // wrap to 0 with overflow, then clear coinciding with an acceptance
        add_accept(1'b0, 1'b0, 5, 0); add_accept(1'b1, 1'b0, 5, 0);
        add_accept(1'b0, 1'b0, 5, 0); add_accept(1'b1, 1'b0, 5, 0);
        add_accept(1'b0, 1'b0, 5, 0); add_accept(1'b1, 1'b1, 5, 1);
        add_accept(1'b0, 1'b0, 5, 0); add_accept(1'b1, 1'b0, 5, 0);
        add_accept(1'b0, 1'b0, 5, 2);

        reset = 1'b0; d_in = 1'b1; en = 1'b1; clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_outs("in_reset", i, zero);
        end
        reset = 1'b1;

        foreach (vecs[i]) step("vec", i, vecs[i]);

        // async reset 15 ns into a cycle while the rise check is in progress
        for (int i = 0; i < 3; i++)
            step("pre_abort", i, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0));
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    #23;
                    d_in = ~d_in;
                end
            end
            begin
                #14;
                reset = 1'b0;
                #1;
                chk_outs("async_rst", 0, zero);
            end
        join
        d_in = 1'b0;
        @(posedge clk);
        #1;
        chk_outs("async_rst", 1, zero);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) step("post_rst", i, zero);
        for (int i = 0; i < 5; i++)
            step("requal", i, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        step("requal", 5, mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0));
        step("requal", 6, mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/latch_debouncer.md
Name: latch_debouncer

Overview:
- Downstream consumer of a level-sensitive latch output, which can glitch while its gate is open.
- Re-times the asynchronous level into `clk` through a synchroniser chain.
- Qualifies each level change with a debounce FSM.
- Emits a clean stable level, single-cycle rise/fall/glitch pulses, and a wrapping count of qualified rising events.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive sampled cycles a new level must hold before acceptance; legal range 2..255.
- CNT_W, 8, width of the qualified-rising-event counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- d_in  input  1  asynchronous level from the upstream latch output (q).
- en  input  1  qualification enable.
- clr_cnt  input  1  synchronous clear of event_cnt and cnt_overflow.
- q_stable  output  1  debounced level.
- rise_pulse  output  1  one-cycle pulse on accepted 0->1.
- fall_pulse  output  1  one-cycle pulse on accepted 1->0.
- glitch_pulse  output  1  one-cycle pulse when a candidate change reverts before acceptance.
- event_cnt  output  CNT_W  count of accepted rising edges; wraps.
- cnt_overflow  output  1  sticky; set when event_cnt wraps from all-ones to 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0):
  - Every flop clears immediately, without waiting for a clock edge.
  - Synchroniser chain is 0, FSM is S_LOW, timer is 0.
  - All outputs are 0.
- All outputs are registered.
- Synchroniser: d_in shifts through SYNC_STAGES flops each edge; s is the last stage.
- FSM states: S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK. Timer width is $clog2(DEBOUNCE_CYCLES+1).
- S_LOW: if en=1 and s=1, go to S_RISE_CHK with timer<=1.
- S_RISE_CHK:
  - s=0: go to S_LOW and assert glitch_pulse for one cycle.
  - s=1 and timer==DEBOUNCE_CYCLES-1: go to S_HIGH, q_stable<=1, assert rise_pulse for one cycle.
  - Otherwise: timer<=timer+1.
- S_HIGH and S_FALL_CHK mirror the rise path with s inverted. Acceptance sets q_stable<=0 and asserts fall_pulse.
- Latency: d_in stable before edge 1 gives a q_stable change and pulse visible after edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults).
  - Minimum accepted pulse width is DEBOUNCE_CYCLES sampled cycles.
- en=0:
  - A checking state returns to its stable state (S_RISE_CHK->S_LOW, S_FALL_CHK->S_HIGH) with no pulse.
  - Stable states hold; q_stable holds.
  - The synchroniser keeps running.
- Pulses are mutually exclusive and never longer than one cycle.
- event_cnt increments on the same edge rise_pulse is asserted.
  - Wraps (2^CNT_W-1)->0 and sets cnt_overflow.
- clr_cnt=1 clears event_cnt and cnt_overflow on that edge.
  - If it coincides with an acceptance, clear wins and that event is not counted; rise_pulse still asserts.
- Reset asserted mid-check: immediate return to reset values; no pulse is emitted afterwards for the aborted check.
- d_in toggling every cycle never reaches acceptance. A glitch_pulse may assert at most once per candidate.

Decomposition:
- Package latch_debouncer_pkg holds:
  - dbnc_state_t enum (S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK);
  - localparam TMR_W function of DEBOUNCE_CYCLES;
  - parameter-range check constants.
- One sub-module, sync_chain (parameter SYNC_STAGES; ports clk, reset, d, q), instantiated once.
- FSM, timer and counter stay in latch_debouncer.

Test Plan:
- Reset: hold reset=0 with d_in=1 and clk running 5 cycles -> all outputs 0; release, then d_in held 1 -> q_stable=1 and rise_pulse=1 six edges later, event_cnt=1.
- Clean fall: from q_stable=1, drive d_in=0 for 20 cycles -> q_stable=0 and fall_pulse=1 for exactly one cycle after edge 6; event_cnt unchanged; glitch_pulse=0 throughout.
- Glitch reject: d_in=1 for exactly 2 clk cycles then 0 (DEBOUNCE_CYCLES=4) -> one glitch_pulse, q_stable stays 0, event_cnt stays 0; d_in toggling each cycle for 30 cycles -> q_stable never changes.
- Wrap/clear (CNT_W=2): 4 clean rises -> event_cnt 1,2,3,0, cnt_overflow=1 after the 4th; clr_cnt=1 on the edge of the 5th acceptance -> event_cnt=0, cnt_overflow=0, rise_pulse=1.
- Enable: d_in 0->1, drop en=0 two cycles into S_RISE_CHK -> no pulses, q_stable=0; raise en=1 with d_in still 1 -> acceptance DEBOUNCE_CYCLES edges later.
- Async reset mid-check: assert reset=0 at 15 ns offset during S_RISE_CHK (clk period 40 ns, d_in toggling every 23 ns) -> all outputs 0 within the same timestep; no glitch or rise pulse after release until a fresh qualification.
